slt_u: RTL and testbench
========================

SLT_U -- requirements
Module: slt_u

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  operands on X/Y are valid this cycle.
REQ-005 Port: X  input  WIDTH  first operand, unsigned.
REQ-006 Port: Y  input  WIDTH  second operand, unsigned.
REQ-007 Port: result  output  WIDTH  registered set-less-than result: bit 0 = (X < Y) unsigned, bits WIDTH-1..1 = 0.
REQ-008 Port: eq  output  1  registered flag: X == Y.
REQ-009 Port: out_valid  output  1  result and eq hold a freshly computed comparison.

Function
REQ-010 The comparison SHALL treat X and Y as unsigned integers; the MSB carries no sign meaning.
REQ-011 The comparator SHALL be built as a WIDTH+1-bit subtraction X - Y; lt = borrow out; eq = all difference bits zero.
REQ-012 result[0] SHALL be 1 iff X < Y; result[WIDTH-1:1] SHALL always be 0.
REQ-013 X == Y SHALL give result = 0 and eq = 1; X > Y SHALL give result = 0 and eq = 0.
REQ-014 Without SLT_U_PIPE_EN: when in_valid = 1 at edge N, result/eq SHALL show the comparison and out_valid = 1 after edge N (latency 1).
REQ-015 When in_valid = 0 at an edge, result and eq SHALL keep their previous values, and out_valid SHALL be 0 after that edge.
REQ-016 Back-to-back in_valid = 1 SHALL be accepted every cycle with no stall; there is no backpressure input.
REQ-017 Boundary operands SHALL compare correctly: 0 vs 2^WIDTH-1 gives 1; 2^WIDTH-1 vs 0 gives 0; 2^(WIDTH-1) vs 1 gives 0.
REQ-018 Outputs SHALL never change between clock edges except on reset assertion.

Reset
REQ-019 rst = 1 SHALL immediately, without waiting for a clock edge, force result = 0, eq = 0, out_valid = 0, and clear all pipeline registers.
REQ-020 While rst = 1, in_valid SHALL be ignored.
REQ-021 The first edge with rst = 0 and in_valid = 1 SHALL be processed normally.
REQ-022 Asserting rst mid-operation SHALL discard any in-flight comparison; no out_valid pulse for it SHALL appear after rst is released.

Configuration
REQ-023 Macro SLT_U_PIPE_EN defined: an input register stage SHALL capture X, Y and in_valid, giving latency 2 edges and throughput 1 per cycle; the REQ-015 hold and out_valid rules apply at the output stage.
REQ-024 Macro SLT_U_PIPE_EN undefined: the input stage SHALL be absent and latency SHALL be 1 edge.

Verification
REQ-025 X=1, Y=2, in_valid=1 -> after latency: result=0x00000001, eq=0, out_valid=1.
REQ-026 X=2, Y=2 -> result=0x00000000, eq=1; then X=3, Y=2 -> result=0x00000000, eq=0.
REQ-027 X=0x80000000, Y=0x00000001 -> result=0; X=0x00000000, Y=0xFFFFFFFF -> result=1 (unsigned check).
REQ-028 Stream of 4 back-to-back pairs, then in_valid=0 -> 4 consecutive out_valid pulses with the matching results; result then holds its last value with out_valid=0.
REQ-029 Assert rst between clock edges while a valid operation is in flight -> result=0 and out_valid=0 immediately; no stale pulse after release.
REQ-030 Run all scenarios with and without SLT_U_PIPE_EN; out_valid latency SHALL be 2 and 1 edges respectively.

Source files
------------

// File: rtl/slt_u.sv
// slt_u: registered unsigned set-less-than comparator.
//   result[0] = (X < Y) unsigned, result[WIDTH-1:1] = 0, eq = (X == Y).
//   Both come from one WIDTH+1-bit subtraction X - Y: the borrow out is
//   "less than", and an all-zero difference is "equal".
// Optional feature macro: SLT_U_PIPE_EN
//   undefined : operands feed the comparator directly, latency 1 edge.
//   defined   : an input register stage captures X/Y/in_valid first,
//               latency 2 edges, still one comparison per cycle.
// Reset is asynchronous and active-high and clears every register,
// including any comparison still in flight.
module slt_u #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] result,
  output logic             eq,
  output logic             out_valid
);

  // Unsigned compare via a zero-extended subtraction.
  // Returns {lt, eq}.
  function automatic logic [1:0] cmp_u(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
    logic [WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return {diff[WIDTH], ~|diff[WIDTH-1:0]};
  endfunction

  logic [WIDTH-1:0] x_p0;
  logic [WIDTH-1:0] y_p0;
  logic             vld_p0;
  logic [1:0]       cmp_p0;

  logic             lt_p1;
  logic             eq_p1;
  logic             vld_p1;

  // ---- stage p0: operand capture (optional) ----
`ifdef SLT_U_PIPE_EN
  // Input register: load operands only on a valid cycle, valid every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_p0   <= '0;
      y_p0   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        x_p0 <= X;
        y_p0 <= Y;
      end
    end
  end
`else
  assign x_p0   = X;
  assign y_p0   = Y;
  assign vld_p0 = in_valid;
`endif

  assign cmp_p0 = cmp_u(x_p0, y_p0);

  // ---- stage p1: registered comparison result ----
  // Result/eq update only on valid input and otherwise hold; out_valid
  // pulses for exactly the cycles carrying a fresh comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lt_p1  <= 1'b0;
      eq_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        lt_p1 <= cmp_p0[1];
        eq_p1 <= cmp_p0[0];
      end
    end
  end

  assign result    = {{(WIDTH-1){1'b0}}, lt_p1};
  assign eq        = eq_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_slt_u.sv
// tb_slt_u: directed self-checking bench for slt_u (WIDTH = 32).
// Build with or without SLT_U_PIPE_EN; the expected latency follows it.
module tb_slt_u;

  localparam int WIDTH = 32;
`ifdef SLT_U_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NVEC = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] result;
  logic             eq;
  logic             out_valid;

  int n_checks;
  int n_errors;

  slt_u #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .X         (X),
    .Y         (Y),
    .result    (result),
    .eq        (eq),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors: operands, valid, hand-computed lt and eq.
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        v;
    logic        lt;
    logic        e;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    vecs[0]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{32'h0000_0002, 32'h0000_0002, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{32'h0000_0005, 32'h0000_0009, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{32'h1234_5678, 32'h1234_5677, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{32'h0000_0001, 32'h0000_0009, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'h0000_0009, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1, 1'b0};
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  logic        exp_lt;
  logic        exp_eq;
  logic        exp_vld;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    X        = '0;
    Y        = '0;

    // Reset asserted before any clock edge: outputs clear at once.
    #1 rst = 1'b1;
    #2;
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_eq", 64'(eq), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);

    // Keep reset across an edge with in_valid high; it must be ignored.
    in_valid = 1'b1;
    X = 32'd1;
    Y = 32'd2;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ignores_valid", 64'(out_valid), 64'd0);
    chk("rst_ignores_result", 64'(result), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;

    // Directed stream: each negedge checks the vector issued LAT cycles
    // earlier, then drives the next vector.
    exp_lt = 1'b0;
    exp_eq = 1'b0;
    for (int j = 0; j < NVEC + LAT; j++) begin
      if (j >= LAT) begin
        exp_vld = vecs[j-LAT].v;
        if (vecs[j-LAT].v) begin
          exp_lt = vecs[j-LAT].lt;
          exp_eq = vecs[j-LAT].e;
        end
      end else begin
        exp_vld = 1'b0;
      end
      if (j > 0) begin
        chk($sformatf("vec%0d_valid", j - LAT), 64'(out_valid), 64'(exp_vld));
        chk($sformatf("vec%0d_result", j - LAT), 64'(result), {32'd0, 31'd0, exp_lt});
        chk($sformatf("vec%0d_eq", j - LAT), 64'(eq), 64'(exp_eq));
      end
      if (j < NVEC) begin
        X        = vecs[j].x;
        Y        = vecs[j].y;
        in_valid = vecs[j].v;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    // Final sample after the drain cycles.
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_hold_result", 64'(result), 64'd1);
    chk("drain_hold_eq", 64'(eq), 64'd0);

    // Mid-flight asynchronous reset between clock edges.
    X = 32'd4;
    Y = 32'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    chk("inflight_valid", 64'(out_valid), (LAT == 1) ? 64'd1 : 64'd0);
    chk("inflight_result", 64'(result), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_result", 64'(result), 64'd0);
    chk("async_rst_eq", 64'(eq), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("no_stale_valid%0d", k), 64'(out_valid), 64'd0);
      chk($sformatf("no_stale_result%0d", k), 64'(result), 64'd0);
    end

    // First valid edge after release is processed normally.
    X = 32'h0000_0004;
    Y = 32'h0000_0004;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
`ifdef SLT_U_PIPE_EN
    chk("post_rst_lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
`endif
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_result", 64'(result), 64'd0);
    chk("post_rst_eq", 64'(eq), 64'd1);
    @(posedge clk);
    #1;
    chk("post_rst_valid_drop", 64'(out_valid), 64'd0);
    chk("post_rst_eq_hold", 64'(eq), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
